// File: rtl/baud_pkg.sv
// Rate table and constant helpers shared by the oversampling baud generator.
// FRAC_DIV_EN selects the phase-accumulator build instead of the integer divisor.
package baud_pkg;

`ifdef FRAC_DIV_EN
    localparam bit FRAC_EN = 1'b1;
`else
    localparam bit FRAC_EN = 1'b0;
`endif

    localparam int unsigned SEL_W     = 3;
    localparam int unsigned NUM_RATES = 8;

    localparam int unsigned BAUD_TABLE [NUM_RATES] = '{
        300, 1200, 4800, 9600, 19200, 38400, 57600, 115200
    };

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

    // round(clk / (baud * os)), clamped to [1, 2^div_w - 1]
    function automatic longint unsigned div_of(input logic [SEL_W-1:0] sel,
                                               input longint unsigned clk_hz,
                                               input longint unsigned os,
                                               input int unsigned div_w);
        longint unsigned den;
        longint unsigned q;
        longint unsigned max_v;
        den   = 64'(BAUD_TABLE[sel]) * os;
        q     = (clk_hz + den / 64'd2) / den;
        max_v = (64'd1 << div_w) - 64'd1;
        if (q < 64'd1) q = 64'd1;
        if (q > max_v) q = max_v;
        return q;
    endfunction

    // round(baud * os * 2^acc_w / clk), clamped to [1, 2^acc_w - 1]
    function automatic longint unsigned inc_of(input logic [SEL_W-1:0] sel,
                                               input longint unsigned clk_hz,
                                               input longint unsigned os,
                                               input int unsigned acc_w);
        longint unsigned num;
        longint unsigned q;
        longint unsigned max_v;
        num   = (64'(BAUD_TABLE[sel]) * os) << acc_w;
        q     = (num + clk_hz / 64'd2) / clk_hz;
        max_v = (64'd1 << acc_w) - 64'd1;
        if (q < 64'd1) q = 64'd1;
        if (q > max_v) q = max_v;
        return q;
    endfunction

endpackage

// File: rtl/baud_rate_rom.sv
// Constant lookup from rate select to divisor (or accumulator increment when
// FRAC_DIV_EN is defined); the whole table is folded at elaboration.
module baud_rate_rom
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned STEP_W      = 16
) (
    input  logic [SEL_W-1:0]  i_sel,
    output logic [STEP_W-1:0] o_step_c
);

    logic [STEP_W-1:0] w_tab [NUM_RATES];

    for (genvar g = 0; g < NUM_RATES; g++) begin : g_tab
        localparam longint unsigned DIV_V =
            div_of(SEL_W'(g), 64'(CLK_FREQ_HZ), 64'(OVERSAMPLE), DIV_W);
        localparam longint unsigned INC_V =
            inc_of(SEL_W'(g), 64'(CLK_FREQ_HZ), 64'(OVERSAMPLE), ACC_W);
        assign w_tab[g] = FRAC_EN ? STEP_W'(INC_V) : STEP_W'(DIV_V);
    end

    assign o_step_c = w_tab[i_sel];

endmodule

// File: rtl/baud_gen_ovs.sv
// Oversampling UART baud generator: sample, bit-centre and bit-end strobes.
// Define FRAC_DIV_EN to replace the integer divisor with a phase accumulator.
module baud_gen_ovs
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned ACC_W       = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SEL_W-1:0]              baud_select,
    input  logic                          enable,
    input  logic                          resync,
    output logic                          sample_ENABLE,
    output logic                          mid_ENABLE,
    output logic                          bit_ENABLE,
    output logic [clog2(OVERSAMPLE)-1:0]  sample_idx
);

    localparam int unsigned STEP_W = FRAC_EN ? ACC_W : DIV_W;
    localparam int unsigned IDX_W  = clog2(OVERSAMPLE);
    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);

    logic [SEL_W-1:0]  r_sel;
    logic [STEP_W-1:0] r_cnt;
    logic [IDX_W-1:0]  r_os_cnt;
    logic [STEP_W-1:0] w_step;
    logic [STEP_W-1:0] w_cnt_nxt;
    logic              w_tick;
    logic              w_restart;

    baud_rate_rom #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .OVERSAMPLE  (OVERSAMPLE),
        .DIV_W       (DIV_W),
        .ACC_W       (ACC_W),
        .STEP_W      (STEP_W)
    ) u_rom (
        .i_sel    (r_sel),
        .o_step_c (w_step)
    );

    assign w_restart = resync || (baud_select != r_sel);

`ifdef FRAC_DIV_EN
    // Carry-out of the phase add is the sample tick.
    logic [STEP_W:0] w_sum;
    assign w_sum     = {1'b0, r_cnt} + {1'b0, w_step};
    assign w_tick    = w_sum[STEP_W];
    assign w_cnt_nxt = w_sum[STEP_W-1:0];
`else
    assign w_tick    = (r_cnt == w_step - STEP_W'(1));
    assign w_cnt_nxt = w_tick ? '0 : r_cnt + STEP_W'(1);
`endif

    // Counters, latched rate and strobes; restart wins over enable and a due tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel         <= baud_select;
            r_cnt         <= '0;
            r_os_cnt      <= '0;
            sample_ENABLE <= 1'b0;
            mid_ENABLE    <= 1'b0;
            bit_ENABLE    <= 1'b0;
        end else begin
            sample_ENABLE <= 1'b0;
            mid_ENABLE    <= 1'b0;
            bit_ENABLE    <= 1'b0;
            r_sel         <= baud_select;
            if (w_restart) begin
                r_cnt    <= '0;
                r_os_cnt <= '0;
            end else if (enable) begin
                r_cnt <= w_cnt_nxt;
                if (w_tick) begin
                    sample_ENABLE <= 1'b1;
                    mid_ENABLE    <= (r_os_cnt == IDX_MID);
                    bit_ENABLE    <= (r_os_cnt == IDX_LAST);
                    r_os_cnt      <= (r_os_cnt == IDX_LAST) ? '0 : r_os_cnt + IDX_W'(1);
                end
            end
        end
    end

    assign sample_idx = r_os_cnt;

endmodule
